uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one physical UART transmitter between N_REQ byte-stream clients.
//  Packets are never interleaved: a grant is held from a client's first byte until its
//  req_last byte has been sent.
//  Clients are served round-robin. An optional client-ID header byte is sent before each packet.
//  Sits between the client logic and the UART PHY's start_tx/byte_tx/done_tx ports.
// PARAMETERS
//  N_REQ        4          number of clients (2..8)
//  HEADER_EN    1          1: send header byte (ID_BASE + client index) before each packet
//  ID_BASE      8'hA0      header base value; the 8-bit sum wraps modulo 256
//  GAP_TIMEOUT  1_000_000  max clk cycles a granted client may stall mid-packet (valid low)
// PORTS
//  clk        in   1        clock
//  rst        in   1        reset
//  req_valid  in   N_REQ    client i has a byte on req_byte[8*i+:8]
//  req_byte   in   8*N_REQ  packed client bytes
//  req_last   in   N_REQ    byte from client i is its packet's last byte
//  req_ready  out  N_REQ    one-hot, 1-cycle pulse: byte of client i accepted this cycle
//  grant      out  N_REQ    one-hot owner of the transmitter; 0 when idle
//  start_tx   out  1        1-cycle launch pulse to the PHY
//  byte_tx    out  8        byte to the PHY
//  done_tx    in   1        PHY idle level (1 = idle); goes 0 on the cycle after start_tx
//  busy       out  1        1 whenever state != IDLE
//  pkt_abort  out  1        1-cycle pulse: packet dropped on gap timeout
// BEHAVIOUR
//  Clocking/reset: one clock; reset is synchronous and active-high.
//  rst=1 at any edge (including mid-frame) forces:
//   - state=IDLE, RR pointer=0
//   - req_ready=0, grant=0, start_tx=0, byte_tx=8'h00, busy=0, pkt_abort=0
//  The frame already in progress in the PHY is not cancelled.
//  After rst, the first launch waits until done_tx=1.
//  States: IDLE, HDR_LAUNCH, WAIT_BUSY, WAIT_DONE, FETCH.
//  - IDLE:
//     - If any req_valid=1 and done_tx=1, grant the first valid client at or after the RR
//       pointer (wrapping N_REQ-1 -> 0). grant is registered.
//     - HEADER_EN=1: go to HDR_LAUNCH with byte_tx=ID_BASE+i.
//     - HEADER_EN=0: go to FETCH.
//  - HDR_LAUNCH: start_tx=1 for exactly one cycle -> WAIT_BUSY.
//  - FETCH:
//     - If req_valid[g]=1: req_ready[g]=1 for this cycle, byte_tx<=req_byte[g], last flag
//       captured, start_tx=1 on the next cycle -> WAIT_BUSY.
//     - If req_valid[g]=0: count gap cycles. At GAP_TIMEOUT, pulse pkt_abort, grant=0 -> IDLE.
//  - WAIT_BUSY: wait for done_tx=0.
//  - WAIT_DONE: wait for done_tx=1, then:
//     - last flag clear, or header just sent: -> FETCH.
//     - last flag set: grant=0, RR pointer=g+1 mod N_REQ -> IDLE.
//  byte_tx must stay constant from the start_tx pulse until done_tx returns to 1;
//  the PHY samples it throughout the frame.
//  Launch rules:
//   - start_tx is never asserted while done_tx=0.
//   - At most one start_tx per frame.
//   - The gap from done_tx rising to the next start_tx is <= 2 cycles.
//  req_ready pulses only for the granted client; all other req_ready bits stay 0.
//  Clients hold req_valid/req_byte/req_last stable until req_ready.
//  A single-byte packet (req_last=1 on the first byte) is legal.
//  The arbitration decision is evaluated only in IDLE; req_valid changes while granted
//  do not move the grant.
//  The gap counter clears on every accepted byte; its width is $clog2(GAP_TIMEOUT+1).
// TESTING (bench PHY model: done_tx=0 for 100 cycles after each start_tx)
//  1. HEADER_EN=1, client 2 sends {11,22(last)} -> PHY sees A2,11,22; then grant=0, busy=0.
//  2. Clients 0,1,3 all valid, 1-byte packets each -> headers in order A0,A1,A3; 3 then 0 next round.
//  3. Client 0 sends 3-byte packet while client 1 valid throughout -> no client-1 byte until
//     client 0's last byte completes.
//  4. HEADER_EN=0, GAP_TIMEOUT=50, client 1 sends one non-last byte then drops valid
//     -> pkt_abort pulse 50 cycles after the frame ends; grant=0.
//  5. Hold done_tx=0 at reset release with client 0 valid -> no start_tx until done_tx=1;
//     byte_tx stable for the whole frame.
//  6. Assert rst during WAIT_DONE -> all outputs at reset values next cycle; the next packet
//     starts with a fresh header.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte-stream clients.
// A grant is held for a whole packet; an optional client-ID header byte precedes each packet.
module uart_tx_scheduler #(
  parameter int          N_REQ       = 4,
  parameter bit          HEADER_EN   = 1'b1,
  parameter logic [7:0]  ID_BASE     = 8'hA0,
  parameter int          GAP_TIMEOUT = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_byte,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               start_tx,
  output logic [7:0]         byte_tx,
  input  logic               done_tx,
  output logic               busy,
  output logic               pkt_abort
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR_LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    FETCH
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_rr;
  logic [IDX_W-1:0]   r_gidx;
  logic [N_REQ-1:0]   r_grant;
  logic [7:0]         r_byte;
  logic               r_last;
  logic               r_hdr;
  logic               r_data_launch;
  logic [GAP_W-1:0]   r_gap;

  logic               w_pick_found;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [N_REQ-1:0]   w_pick_onehot;
  logic [N_REQ-1:0]   w_gidx_onehot;
  logic [7:0]         w_hdr_byte;
  logic [IDX_W-1:0]   w_rr_next;
  logic               w_fetch_ok;
  logic               w_gap_expired;
  logic               w_idle_go;

  // Round-robin search: the lowest offset from the pointer wins, so scan offsets downwards.
  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    int j;
    j            = 0;
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(r_rr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req_valid[j]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = IDX_W'(j);
      end
    end
  end

  assign w_pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
  assign w_gidx_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_gidx;
  assign w_hdr_byte    = ID_BASE + 8'(w_pick_idx);
  assign w_rr_next     = (r_gidx == IDX_W'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;
  assign w_fetch_ok    = req_valid[r_gidx];
  assign w_gap_expired = (r_gap == GAP_W'(GAP_TIMEOUT - 1));
  assign w_idle_go     = w_pick_found && done_tx;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:       if (w_idle_go) w_state_nxt = HEADER_EN ? HDR_LAUNCH : FETCH;
      HDR_LAUNCH: w_state_nxt = WAIT_BUSY;
      WAIT_BUSY:  if (!done_tx) w_state_nxt = WAIT_DONE;
      WAIT_DONE:  if (done_tx) w_state_nxt = (r_last && !r_hdr) ? IDLE : FETCH;
      FETCH: begin
        if (w_fetch_ok)         w_state_nxt = WAIT_BUSY;
        else if (w_gap_expired) w_state_nxt = IDLE;
      end
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Header launches come from HDR_LAUNCH; data launches are the registered accept from FETCH,
  // which lands in the first WAIT_BUSY cycle.
  always_comb begin
    start_tx  = (r_state == HDR_LAUNCH) || r_data_launch;
    req_ready = '0;
    pkt_abort = 1'b0;
    if (r_state == FETCH) begin
      if (w_fetch_ok) req_ready = w_gidx_onehot;
      else            pkt_abort = w_gap_expired;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr          <= '0;
      r_gidx        <= '0;
      r_grant       <= '0;
      r_byte        <= 8'h00;
      r_last        <= 1'b0;
      r_hdr         <= 1'b0;
      r_data_launch <= 1'b0;
      r_gap         <= '0;
    end else begin
      r_data_launch <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_idle_go) begin
            r_gidx  <= w_pick_idx;
            r_grant <= w_pick_onehot;
            r_gap   <= '0;
            r_last  <= 1'b0;
            r_hdr   <= HEADER_EN;
            if (HEADER_EN) r_byte <= w_hdr_byte;
          end
        end
        WAIT_DONE: begin
          if (done_tx && r_last && !r_hdr) begin
            r_grant <= '0;
            r_rr    <= w_rr_next;
          end
        end
        FETCH: begin
          if (w_fetch_ok) begin
            r_byte        <= req_byte[8*r_gidx +: 8];
            r_last        <= req_last[r_gidx];
            r_hdr         <= 1'b0;
            r_gap         <= '0;
            r_data_launch <= 1'b1;
          end else if (w_gap_expired) begin
            // A stalled client loses its turn just as if the packet had completed.
            r_grant <= '0;
            r_rr    <= w_rr_next;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant   = r_grant;
  assign byte_tx = r_byte;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a header-enabled instance and a header-less short-timeout instance,
// each attached to a PHY model that holds done_tx low for 100 cycles after every launch.
module tb_uart_tx_scheduler;

  localparam int N     = 4;
  localparam int FRAME = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           sel_b;
  logic           force_low;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [8*N-1:0] req_byte;
  logic [N-1:0]   valid_a, valid_b;
  logic [N-1:0]   ready_a, ready_b, grant_a, grant_b;
  logic [1:0]     start_v, done_v, busy_v, abort_v, phy_done;
  logic [1:0][7:0] btx_v;

  assign valid_a = sel_b ? '0 : req_valid;
  assign valid_b = sel_b ? req_valid : '0;
  assign done_v  = phy_done & {1'b1, ~force_low};

  uart_tx_scheduler #(.N_REQ(N), .HEADER_EN(1'b1), .ID_BASE(8'hA0), .GAP_TIMEOUT(1_000_000)) u_dut_hdr (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_byte(req_byte), .req_last(req_last),
    .req_ready(ready_a), .grant(grant_a), .start_tx(start_v[0]), .byte_tx(btx_v[0]),
    .done_tx(done_v[0]), .busy(busy_v[0]), .pkt_abort(abort_v[0])
  );

  uart_tx_scheduler #(.N_REQ(N), .HEADER_EN(1'b0), .ID_BASE(8'hA0), .GAP_TIMEOUT(50)) u_dut_nohdr (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_byte(req_byte), .req_last(req_last),
    .req_ready(ready_b), .grant(grant_b), .start_tx(start_v[1]), .byte_tx(btx_v[1]),
    .done_tx(done_v[1]), .busy(busy_v[1]), .pkt_abort(abort_v[1])
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int cyc      = 0;
  int viol[2];
  int stab_err[2];
  int phy_cnt[2];
  int rise_cyc[2];
  int abort_cnt;
  int abort_cyc;
  bit taint[2];
  logic [7:0] cur_byte[2];
  logic [7:0] launch_q0[$];
  logic [7:0] launch_q1[$];
  logic [7:0] exp_q[$];
  logic [8:0] cq [N][$];

  always @(posedge clk) cyc <= cyc + 1;

  // PHY model and protocol monitor, sampled on the falling edge.
  initial begin
    phy_done = 2'b11;
    abort_cnt = 0;
    abort_cyc = 0;
    for (int u = 0; u < 2; u++) begin
      viol[u] = 0; stab_err[u] = 0; phy_cnt[u] = 0; rise_cyc[u] = 0; taint[u] = 1'b0; cur_byte[u] = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (rst) taint[u] = 1'b1;
        if (start_v[u]) begin
          if (!done_v[u]) viol[u]++;
          if (u == 0) launch_q0.push_back(btx_v[0]);
          else        launch_q1.push_back(btx_v[1]);
          phy_done[u] = 1'b0;
          phy_cnt[u]  = FRAME;
          cur_byte[u] = btx_v[u];
          taint[u]    = rst;
        end else if (phy_cnt[u] > 0) begin
          if (!taint[u] && btx_v[u] !== cur_byte[u]) stab_err[u]++;
          phy_cnt[u]--;
          if (phy_cnt[u] == 0) begin
            phy_done[u] = 1'b1;
            rise_cyc[u] = cyc;
          end
        end
      end
      if ((ready_a & ~grant_a) != '0 || $countones(ready_a) > 1) viol[0]++;
      if ((ready_b & ~grant_b) != '0 || $countones(ready_b) > 1) viol[1]++;
      if (abort_v[1]) begin
        abort_cnt++;
        abort_cyc = cyc;
      end
    end
  end

  // Client model: each client presents the head of its queue until req_ready takes it.
  initial begin
    logic [N-1:0] rdy;
    logic [8:0]   e;
    req_valid = '0;
    req_last  = '0;
    req_byte  = '0;
    forever begin
      @(negedge clk);
      rdy = sel_b ? ready_b : ready_a;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rdy[i] && cq[i].size() > 0) cq[i].delete(0);
        if (cq[i].size() > 0) begin
          e = cq[i][0];
          req_valid[i]       = 1'b1;
          req_last[i]        = e[8];
          req_byte[8*i +: 8] = e[7:0];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic int lq_size(input int u);
    return (u == 0) ? launch_q0.size() : launch_q1.size();
  endfunction

  function automatic logic [7:0] lq_pop(input int u);
    if (u == 0) return launch_q0.pop_front();
    return launch_q1.pop_front();
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int c, input logic [7:0] b, input bit last);
    cq[c].push_back({last, b});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    launch_q0.delete();
    launch_q1.delete();
    exp_q.delete();
  endtask

  task automatic wait_phy_idle(input int u, input string tag);
    int n = 0;
    while (!(phy_done[u] && phy_cnt[u] == 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    vec_cnt++;
    if (n >= 1000) begin
      miss_cnt++;
      $display("FAIL %s phy_idle: still busy after %0d cycles, want idle", tag, n);
    end
  endtask

  // Scoreboard drain: pop every expected launch byte and compare with what the PHY saw.
  task automatic drain(input int u, input string tag, input int budget);
    int n = 0;
    logic [7:0] e, act;
    while (lq_size(u) < exp_q.size() && n < budget) begin
      @(negedge clk);
      n++;
    end
    vec_cnt++;
    if (lq_size(u) != exp_q.size()) begin
      miss_cnt++;
      $display("FAIL %s launch_count: got %0d, want %0d", tag, lq_size(u), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = (lq_size(u) > 0) ? lq_pop(u) : 8'hxx;
      vec_cnt++;
      if (act !== e) begin
        miss_cnt++;
        $display("FAIL %s launch_byte: got %h, want %h", tag, act, e);
      end
    end
  endtask

  task automatic check_idle(input int u, input string tag);
    logic [N-1:0] g;
    wait_phy_idle(u, tag);
    tick(3);
    g = (u == 0) ? grant_a : grant_b;
    vec_cnt++;
    if ({g, busy_v[u]} !== '0) begin
      miss_cnt++;
      $display("FAIL %s idle: grant=%b busy=%b, want grant=0 busy=0", tag, g, busy_v[u]);
    end
    vec_cnt++;
    if (viol[u] !== 0) begin
      miss_cnt++;
      $display("FAIL %s protocol: %0d launch/ready violations, want 0", tag, viol[u]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    vec_cnt++;
    if ({grant_a, ready_a, start_v[0], btx_v[0], busy_v[0], abort_v[0]} !== '0) begin
      miss_cnt++;
      $display("FAIL %s hdr_outputs: grant=%b ready=%b start=%b byte=%h busy=%b abort=%b, want all 0",
               tag, grant_a, ready_a, start_v[0], btx_v[0], busy_v[0], abort_v[0]);
    end
    vec_cnt++;
    if ({grant_b, ready_b, start_v[1], btx_v[1], busy_v[1], abort_v[1]} !== '0) begin
      miss_cnt++;
      $display("FAIL %s nohdr_outputs: grant=%b ready=%b start=%b byte=%h busy=%b abort=%b, want all 0",
               tag, grant_b, ready_b, start_v[1], btx_v[1], busy_v[1], abort_v[1]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(3);
    check_reset_outputs("reset_idle");
  endtask

  task automatic test_single_packet();
    do_reset();
    exp_q.push_back(8'hA2); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    send(2, 8'h11, 1'b0);
    send(2, 8'h22, 1'b1);
    drain(0, "single_packet", 1500);
    check_idle(0, "single_packet");
  endtask

  task automatic test_round_robin();
    do_reset();
    send(0, 8'h10, 1'b1);
    send(0, 8'h40, 1'b1);
    send(1, 8'h20, 1'b1);
    send(3, 8'h30, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h10);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h20);
    exp_q.push_back(8'hA3); exp_q.push_back(8'h30);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h40);
    drain(0, "round_robin", 3000);
    check_idle(0, "round_robin");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    do_reset();
    send(0, 8'h01, 1'b0);
    send(0, 8'h02, 1'b0);
    send(0, 8'h03, 1'b1);
    send(1, 8'h0B, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'h03); exp_q.push_back(8'hA1); exp_q.push_back(8'h0B);
    while (lq_size(0) < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tick(5);
    vec_cnt++;
    if (grant_a !== 4'b0001) begin
      miss_cnt++;
      $display("FAIL back_to_back mid_grant: got %b, want 0001", grant_a);
    end
    drain(0, "back_to_back", 2000);
    check_idle(0, "back_to_back");
  endtask

  task automatic test_gap_timeout();
    int n = 0;
    do_reset();
    sel_b = 1'b1;
    abort_cnt = 0;
    send(1, 8'h5A, 1'b0);
    exp_q.push_back(8'h5A);
    drain(1, "gap_timeout", 500);
    while (abort_cnt == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tick(3);
    vec_cnt++;
    if (abort_cnt !== 1) begin
      miss_cnt++;
      $display("FAIL gap_timeout abort_pulses: got %0d, want 1", abort_cnt);
    end
    vec_cnt++;
    if (abort_cyc - rise_cyc[1] !== 50) begin
      miss_cnt++;
      $display("FAIL gap_timeout abort_delay: got %0d, want 50", abort_cyc - rise_cyc[1]);
    end
    check_idle(1, "gap_timeout");
    sel_b = 1'b0;
  endtask

  task automatic test_done_hold();
    wait_phy_idle(0, "done_hold_pre");
    force_low = 1'b1;
    do_reset();
    send(0, 8'h55, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h55);
    tick(30);
    vec_cnt++;
    if (lq_size(0) !== 0) begin
      miss_cnt++;
      $display("FAIL done_hold early_launch: got %0d launches, want 0", lq_size(0));
    end
    vec_cnt++;
    if (grant_a !== 4'b0000) begin
      miss_cnt++;
      $display("FAIL done_hold early_grant: got %b, want 0000", grant_a);
    end
    force_low = 1'b0;
    drain(0, "done_hold", 600);
    check_idle(0, "done_hold");
    vec_cnt++;
    if (stab_err[0] !== 0) begin
      miss_cnt++;
      $display("FAIL done_hold byte_stable: got %0d changes mid-frame, want 0", stab_err[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    wait_phy_idle(0, "mid_reset_pre");
    do_reset();
    send(0, 8'h61, 1'b0);
    send(0, 8'h62, 1'b0);
    send(0, 8'h63, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h61);
    drain(0, "mid_reset_first", 600);
    tick(10);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    exp_q.push_back(8'hA0); exp_q.push_back(8'h62); exp_q.push_back(8'h63);
    drain(0, "mid_reset_resume", 1000);
    check_idle(0, "mid_reset");
    vec_cnt++;
    if (stab_err[0] !== 0) begin
      miss_cnt++;
      $display("FAIL mid_reset byte_stable: got %0d changes mid-frame, want 0", stab_err[0]);
    end
  endtask

  initial begin
    rst       = 1'b1;
    sel_b     = 1'b0;
    force_low = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_back_to_back();
    test_done_hold();
    test_reset_mid_frame();
    test_gap_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
